// File: rtl/id_stage.sv
// Instruction-decode stage: register-bank address presentation, decode, load-use bubble insertion.
// Optional performance counters are enabled by defining ID_PERF_CNT_EN.
module id_stage #(
    parameter int unsigned LOAD_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_f,
    input  logic [31:0] pc_f,
    input  logic        valid_f,
    input  logic        flush,
    input  logic        hold_in,
    output logic        stall_f,
    output logic [3:0]  rb_addr_a,
    output logic [3:0]  rb_addr_b,
    output logic        rb_clear,
    output logic        rb_hold,
    output logic        valid_e,
    output logic [31:0] instr_e,
    output logic [31:0] pc_e,
    output logic [3:0]  opcode_e,
    output logic [3:0]  dreg_e,
    output logic        we_e,
    output logic        is_load_e
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0] perf_bubble_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_LOAD   = 4'b0101;
    localparam logic [3:0] OP_STORE  = 4'b0110;
    localparam logic [3:0] OP_BRANCH = 4'b0111;
    localparam logic [1:0] BCNT_INIT = 2'(LOAD_BUBBLES - 1);

    state_t     state_q, state_d;
    logic [1:0] bcnt_q, bcnt_d;
    logic       hazard;
    logic       bubble;
    logic       load_instr;
    logic       kill;

    logic [3:0] op_f, areg_f, breg_f, dreg_f;
    logic       we_f;

    assign op_f   = instr_f[31:28];
    assign areg_f = instr_f[11:8];
    assign breg_f = instr_f[7:4];
    assign dreg_f = instr_f[3:0];

    assign rb_addr_a = areg_f;
    assign rb_addr_b = breg_f;

    assign we_f = (dreg_f != 4'd0) && (op_f != OP_NOP) && (op_f != OP_STORE) && (op_f != OP_BRANCH);

    assign hazard = valid_f && valid_e && is_load_e && (dreg_e != 4'd0)
                    && ((dreg_e == areg_f) || (dreg_e == breg_f));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        bubble     = 1'b0;
        load_instr = 1'b0;
        kill       = 1'b0;
        if (flush) begin
            state_d = RUN;
            bcnt_d  = '0;
            kill    = 1'b1;
        end else if (!hold_in) begin
            case (state_q)
                RUN: begin
                    if (hazard) begin
                        bubble  = 1'b1;
                        bcnt_d  = BCNT_INIT;
                        state_d = (LOAD_BUBBLES > 1) ? STALL : RUN;
                    end else begin
                        load_instr = 1'b1;
                    end
                end
                STALL: begin
                    bubble = 1'b1;
                    // bcnt holds the bubbles still owed; the last one returns to RUN
                    if (bcnt_q <= 2'd1) begin
                        bcnt_d  = '0;
                        state_d = RUN;
                    end else begin
                        bcnt_d = bcnt_q - 2'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
        rb_clear = flush || bubble;
        rb_hold  = hold_in && !flush;
        stall_f  = !flush && (hold_in || ((state_q == RUN) && hazard) || (state_q == STALL));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_e   <= 1'b0;
            instr_e   <= '0;
            pc_e      <= '0;
            opcode_e  <= '0;
            dreg_e    <= '0;
            we_e      <= 1'b0;
            is_load_e <= 1'b0;
        end else if (kill || bubble || (load_instr && !valid_f)) begin
            valid_e   <= 1'b0;
            instr_e   <= '0;
            pc_e      <= '0;
            opcode_e  <= '0;
            dreg_e    <= '0;
            we_e      <= 1'b0;
            is_load_e <= 1'b0;
        end else if (load_instr) begin
            valid_e   <= 1'b1;
            instr_e   <= instr_f;
            pc_e      <= pc_f;
            opcode_e  <= op_f;
            dreg_e    <= dreg_f;
            we_e      <= we_f;
            is_load_e <= (op_f == OP_LOAD);
        end
    end

`ifdef ID_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_bubble_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else if (!hold_in) begin
            if (bubble) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            if (flush)  perf_flush_cnt  <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: one instance at LOAD_BUBBLES=2, one at LOAD_BUBBLES=3.
module tb_id_stage;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // instance A: LOAD_BUBBLES = 2
    logic [31:0] a_instr_f, a_pc_f;
    logic        a_valid_f, a_flush, a_hold_in;
    logic        a_stall_f, a_rb_clear, a_rb_hold, a_valid_e, a_we_e, a_is_load_e;
    logic [3:0]  a_rb_addr_a, a_rb_addr_b, a_opcode_e, a_dreg_e;
    logic [31:0] a_instr_e, a_pc_e;
`ifdef ID_PERF_CNT_EN
    logic [31:0] a_perf_bubble_cnt, a_perf_flush_cnt;
    logic [31:0] b_perf_bubble_cnt, b_perf_flush_cnt;
`endif

    // instance B: LOAD_BUBBLES = 3
    logic [31:0] b_instr_f, b_pc_f;
    logic        b_valid_f, b_flush, b_hold_in;
    logic        b_stall_f, b_rb_clear, b_rb_hold, b_valid_e, b_we_e, b_is_load_e;
    logic [3:0]  b_rb_addr_a, b_rb_addr_b, b_opcode_e, b_dreg_e;
    logic [31:0] b_instr_e, b_pc_e;

    id_stage #(.LOAD_BUBBLES(2)) u_a (
        .clk(clk), .reset(reset),
        .instr_f(a_instr_f), .pc_f(a_pc_f), .valid_f(a_valid_f),
        .flush(a_flush), .hold_in(a_hold_in),
        .stall_f(a_stall_f), .rb_addr_a(a_rb_addr_a), .rb_addr_b(a_rb_addr_b),
        .rb_clear(a_rb_clear), .rb_hold(a_rb_hold),
        .valid_e(a_valid_e), .instr_e(a_instr_e), .pc_e(a_pc_e),
        .opcode_e(a_opcode_e), .dreg_e(a_dreg_e), .we_e(a_we_e), .is_load_e(a_is_load_e)
`ifdef ID_PERF_CNT_EN
        , .perf_bubble_cnt(a_perf_bubble_cnt), .perf_flush_cnt(a_perf_flush_cnt)
`endif
    );

    id_stage #(.LOAD_BUBBLES(3)) u_b (
        .clk(clk), .reset(reset),
        .instr_f(b_instr_f), .pc_f(b_pc_f), .valid_f(b_valid_f),
        .flush(b_flush), .hold_in(b_hold_in),
        .stall_f(b_stall_f), .rb_addr_a(b_rb_addr_a), .rb_addr_b(b_rb_addr_b),
        .rb_clear(b_rb_clear), .rb_hold(b_rb_hold),
        .valid_e(b_valid_e), .instr_e(b_instr_e), .pc_e(b_pc_e),
        .opcode_e(b_opcode_e), .dreg_e(b_dreg_e), .we_e(b_we_e), .is_load_e(b_is_load_e)
`ifdef ID_PERF_CNT_EN
        , .perf_bubble_cnt(b_perf_bubble_cnt), .perf_flush_cnt(b_perf_flush_cnt)
`endif
    );

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rd);
        return {op, 16'h0000, ra, rb, rd};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // inputs change 2 time units after the active edge; checks happen there too
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] add_r3, ld_r5, add_r6, ld_r0, add_r7, ld_r8, ld_r9, st_r4, add_r9;

    initial begin
        add_r3 = enc(4'h1, 4'd1, 4'd2, 4'd3);
        ld_r5  = enc(4'h5, 4'd1, 4'd2, 4'd5);
        add_r6 = enc(4'h1, 4'd5, 4'd1, 4'd6);
        ld_r0  = enc(4'h5, 4'd1, 4'd2, 4'd0);
        add_r7 = enc(4'h1, 4'd0, 4'd0, 4'd7);
        ld_r8  = enc(4'h5, 4'd1, 4'd2, 4'd8);
        ld_r9  = enc(4'h5, 4'd8, 4'd0, 4'd9);
        st_r4  = enc(4'h6, 4'd1, 4'd2, 4'd4);
        add_r9 = enc(4'h1, 4'd1, 4'd2, 4'd9);

        reset = 1'b0;
        a_instr_f = add_r3; a_pc_f = 32'h0000_0100; a_valid_f = 1'b1; a_flush = 1'b0; a_hold_in = 1'b0;
        b_instr_f = '0;     b_pc_f = '0;            b_valid_f = 1'b0; b_flush = 1'b0; b_hold_in = 1'b0;

        // reset held with a valid instruction presented
        tick();
        tick();
        chk("rst_valid_e", a_valid_e, 1'b0);
        chk("rst_instr_e", a_instr_e, 32'h0);
        chk("rst_pc_e", a_pc_e, 32'h0);
        chk("rst_dreg_e", a_dreg_e, 4'd0);
        chk("rst_we_e", a_we_e, 1'b0);
        chk("rst_is_load_e", a_is_load_e, 1'b0);
        chk("rst_rb_addr_a", a_rb_addr_a, 4'd1);
        chk("rst_rb_addr_b", a_rb_addr_b, 4'd2);
        reset = 1'b1;
        #1;
        chk("first_stall_f", a_stall_f, 1'b0);
        tick();
        chk("first_valid_e", a_valid_e, 1'b1);
        chk("first_dreg_e", a_dreg_e, 4'd3);
        chk("first_we_e", a_we_e, 1'b1);
        chk("first_pc_e", a_pc_e, 32'h0000_0100);
        chk("first_opcode_e", a_opcode_e, 4'h1);

        // load-use with two bubbles
        a_instr_f = ld_r5; a_pc_f = 32'h0000_0104;
        #1;
        chk("lu_ld_stall_f", a_stall_f, 1'b0);
        tick();
        chk("lu_ld_valid_e", a_valid_e, 1'b1);
        chk("lu_ld_is_load_e", a_is_load_e, 1'b1);
        a_instr_f = add_r6; a_pc_f = 32'h0000_0108;
        #1;
        chk("lu_h_stall_f", a_stall_f, 1'b1);
        chk("lu_h_rb_clear", a_rb_clear, 1'b1);
        chk("lu_h_rb_addr_a", a_rb_addr_a, 4'd5);
        tick();
        chk("lu_b1_valid_e", a_valid_e, 1'b0);
        chk("lu_b1_instr_e", a_instr_e, 32'h0);
        chk("lu_b1_stall_f", a_stall_f, 1'b1);
        chk("lu_b1_rb_clear", a_rb_clear, 1'b1);
        chk("lu_b1_rb_addr_b", a_rb_addr_b, 4'd1);
        tick();
        chk("lu_b2_valid_e", a_valid_e, 1'b0);
        chk("lu_b2_stall_f", a_stall_f, 1'b0);
        chk("lu_b2_rb_clear", a_rb_clear, 1'b0);
        tick();
        chk("lu_use_valid_e", a_valid_e, 1'b1);
        chk("lu_use_dreg_e", a_dreg_e, 4'd6);
        chk("lu_use_pc_e", a_pc_e, 32'h0000_0108);

        // load to r0 never creates a hazard
        a_instr_f = ld_r0; a_pc_f = 32'h0000_010C;
        tick();
        chk("r0_ld_we_e", a_we_e, 1'b0);
        chk("r0_ld_is_load_e", a_is_load_e, 1'b1);
        a_instr_f = add_r7; a_pc_f = 32'h0000_0110;
        #1;
        chk("r0_use_stall_f", a_stall_f, 1'b0);
        chk("r0_use_rb_clear", a_rb_clear, 1'b0);
        tick();
        chk("r0_use_valid_e", a_valid_e, 1'b1);
        chk("r0_use_dreg_e", a_dreg_e, 4'd7);

        // dependent load chain stalls at the link
        a_instr_f = ld_r8; a_pc_f = 32'h0000_0114;
        tick();
        a_instr_f = ld_r9; a_pc_f = 32'h0000_0118;
        #1;
        chk("chain_stall_f", a_stall_f, 1'b1);
        tick();
        chk("chain_b1_valid_e", a_valid_e, 1'b0);
        tick();
        chk("chain_b2_valid_e", a_valid_e, 1'b0);
        tick();
        chk("chain_ld_valid_e", a_valid_e, 1'b1);
        chk("chain_ld_dreg_e", a_dreg_e, 4'd9);

        // flush beats a pending hazard
        a_instr_f = enc(4'h1, 4'd9, 4'd9, 4'd1); a_flush = 1'b1;
        #1;
        chk("fl_stall_f", a_stall_f, 1'b0);
        chk("fl_rb_clear", a_rb_clear, 1'b1);
        tick();
        a_flush = 1'b0;
        chk("fl_valid_e", a_valid_e, 1'b0);
`ifdef ID_PERF_CNT_EN
        chk("perf_bubble_cnt", a_perf_bubble_cnt, 32'd4);
        chk("perf_flush_cnt", a_perf_flush_cnt, 32'd1);
`endif

        // hold for three cycles, then flush during hold
        a_instr_f = 32'h1234_5673; a_pc_f = 32'h0000_0200;
        tick();
        chk("hold_pre_instr_e", a_instr_e, 32'h1234_5673);
        a_hold_in = 1'b1; a_instr_f = st_r4; a_pc_f = 32'h0000_0204;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_rb_hold", a_rb_hold, 1'b1);
            chk("hold_stall_f", a_stall_f, 1'b1);
            tick();
            chk("hold_instr_e", a_instr_e, 32'h1234_5673);
            chk("hold_valid_e", a_valid_e, 1'b1);
        end
        a_flush = 1'b1;
        #1;
        chk("hfl_rb_hold", a_rb_hold, 1'b0);
        chk("hfl_stall_f", a_stall_f, 1'b0);
        chk("hfl_rb_clear", a_rb_clear, 1'b1);
        tick();
        chk("hfl_valid_e", a_valid_e, 1'b0);
        chk("hfl_instr_e", a_instr_e, 32'h0);
        a_flush = 1'b0; a_hold_in = 1'b0;
        tick();
        chk("store_valid_e", a_valid_e, 1'b1);
        chk("store_we_e", a_we_e, 1'b0);
        a_valid_f = 1'b0;
        tick();
        chk("invalid_valid_e", a_valid_e, 1'b0);

        // instance B: flush on the second bubble of a three-bubble stall
        b_instr_f = ld_r5; b_pc_f = 32'h0000_0300; b_valid_f = 1'b1;
        tick();
        chk("b_ld_valid_e", b_valid_e, 1'b1);
        b_instr_f = add_r6; b_pc_f = 32'h0000_0304;
        #1;
        chk("b_h_stall_f", b_stall_f, 1'b1);
        tick();
        chk("b_b1_valid_e", b_valid_e, 1'b0);
        chk("b_b1_stall_f", b_stall_f, 1'b1);
        b_flush = 1'b1;
        #1;
        chk("b_fl_stall_f", b_stall_f, 1'b0);
        chk("b_fl_rb_clear", b_rb_clear, 1'b1);
        tick();
        b_flush = 1'b0; b_instr_f = add_r9; b_pc_f = 32'h0000_0400;
        chk("b_fl_valid_e", b_valid_e, 1'b0);
        #1;
        chk("b_post_stall_f", b_stall_f, 1'b0);
        tick();
        chk("b_post_valid_e", b_valid_e, 1'b1);
        chk("b_post_dreg_e", b_dreg_e, 4'd9);
        chk("b_post_pc_e", b_pc_e, 32'h0000_0400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
